// File: rtl/clock_enable_gen.sv
// PLL lock filter, downstream reset generator and CHANNELS phase-aligned clock-enable dividers.
// Optional lock-loss counter enabled by defining CLOCK_ENABLE_GEN_LOSS_COUNT_EN.
module clock_enable_gen #(
    parameter int CHANNELS       = 2,
    parameter int DIV_WIDTH      = 8,
    parameter int DIV_DEFAULT    = 2,
    parameter int LOCK_CYCLES    = 1024,
    parameter int LOCK_CNT_WIDTH = 10
) (
    input  logic                          clock_in,
    input  logic                          reset_n,
    input  logic                          pll_locked,
    input  logic [CHANNELS*DIV_WIDTH-1:0] div_i,
    input  logic                          div_load,
    output logic                          locked,
    output logic                          rst_out_n,
`ifdef CLOCK_ENABLE_GEN_LOSS_COUNT_EN
    output logic [7:0]                    lock_loss_count,
`endif
    output logic [CHANNELS-1:0]           clk_en
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        LOCKED    = 2'd2
    } lock_state_t;

    localparam logic [LOCK_CNT_WIDTH-1:0] CNT_ZERO  = LOCK_CNT_WIDTH'(0);
    localparam logic [LOCK_CNT_WIDTH-1:0] CNT_ONE   = LOCK_CNT_WIDTH'(1);
    localparam logic [LOCK_CNT_WIDTH-1:0] CNT_LAST  = LOCK_CNT_WIDTH'(LOCK_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0]      DIV_ZERO  = DIV_WIDTH'(0);
    localparam logic [DIV_WIDTH-1:0]      DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0]      DIV_RESET = DIV_WIDTH'(DIV_DEFAULT);

    logic                      sync_r;
    logic                      pl_s;
    lock_state_t               state_r;
    lock_state_t               state_s;
    logic [LOCK_CNT_WIDTH-1:0] lock_cnt_r;
    logic [LOCK_CNT_WIDTH-1:0] lock_cnt_s;
    logic                      locked_r;
    logic                      rst_out_r;
    logic                      lock_nxt_s;
    logic                      run_s;
    logic [CHANNELS-1:0]       en_r;

    // Two-flop synchroniser for the asynchronous PLL lock input.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 1'b0;
            pl_s   <= 1'b0;
        end else begin
            sync_r <= pll_locked;
            pl_s   <= sync_r;
        end
    end

    // Lock filter state and counter registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= WAIT_LOCK;
            lock_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            lock_cnt_r <= lock_cnt_s;
        end
    end

    // Lock filter next state: any low sample outside LOCKED restarts the full count.
    always_comb begin
        state_s    = state_r;
        lock_cnt_s = lock_cnt_r;
        case (state_r)
            WAIT_LOCK: begin
                lock_cnt_s = CNT_ZERO;
                if (pl_s) begin
                    state_s = COUNT;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            COUNT: begin
                if (!pl_s) begin
                    state_s    = WAIT_LOCK;
                    lock_cnt_s = CNT_ZERO;
                end else if (lock_cnt_r == CNT_LAST) begin
                    state_s    = LOCKED;
                    lock_cnt_s = CNT_ZERO;
                end else begin
                    state_s    = COUNT;
                    lock_cnt_s = lock_cnt_r + CNT_ONE;
                end
            end
            LOCKED: begin
                lock_cnt_s = CNT_ZERO;
                if (!pl_s) begin
                    state_s = WAIT_LOCK;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s    = WAIT_LOCK;
                lock_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // Dividers run only while locked now and staying locked, so lock loss clears them on the falling cycle.
    assign lock_nxt_s = (state_s == LOCKED);
    assign run_s      = locked_r & lock_nxt_s;

    // Registered lock flag and downstream reset; reset release lags lock by one cycle, drop is not delayed.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            locked_r  <= 1'b0;
            rst_out_r <= 1'b0;
        end else begin
            locked_r  <= lock_nxt_s;
            rst_out_r <= lock_nxt_s & locked_r;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [DIV_WIDTH-1:0] shadow_r;
        logic [DIV_WIDTH-1:0] cnt_r;

        // Per-channel divisor shadow, phase counter and enable pulse.
        always_ff @(posedge clock_in or negedge reset_n) begin
            if (!reset_n) begin
                shadow_r <= DIV_RESET;
                cnt_r    <= DIV_ZERO;
                en_r[i]  <= 1'b0;
            end else if (div_load) begin
                shadow_r <= div_i[i*DIV_WIDTH +: DIV_WIDTH];
                cnt_r    <= DIV_ZERO;
                en_r[i]  <= 1'b0;
            end else if (!run_s || (shadow_r == DIV_ZERO)) begin
                cnt_r    <= DIV_ZERO;
                en_r[i]  <= 1'b0;
            end else if (cnt_r == (shadow_r - DIV_ONE)) begin
                cnt_r    <= DIV_ZERO;
                en_r[i]  <= 1'b1;
            end else begin
                cnt_r    <= cnt_r + DIV_ONE;
                en_r[i]  <= 1'b0;
            end
        end
    end

`ifdef CLOCK_ENABLE_GEN_LOSS_COUNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating count of LOCKED -> WAIT_LOCK transitions; cleared only by reset_n.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt_r <= 8'd0;
        end else if ((state_r == LOCKED) && (state_s == WAIT_LOCK) && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign lock_loss_count = loss_cnt_r;
`endif

    assign locked    = locked_r;
    assign rst_out_n = rst_out_r;
    assign clk_en    = en_r;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomised self-checking bench for clock_enable_gen against a cycle-level behavioural model.
module tb_clock_enable_gen;

    localparam int CH   = 2;
    localparam int DW   = 8;
    localparam int DDEF = 2;
    localparam int LC   = 16;
    localparam int LCW  = 5;

    logic             clock_in = 1'b0;
    logic             reset_n;
    logic             pll_locked;
    logic [CH*DW-1:0] div_i;
    logic             div_load;
    logic             locked;
    logic             rst_out_n;
    logic [CH-1:0]    clk_en;
`ifdef CLOCK_ENABLE_GEN_LOSS_COUNT_EN
    logic [7:0]       lock_loss_count;
`endif

    clock_enable_gen #(
        .CHANNELS(CH), .DIV_WIDTH(DW), .DIV_DEFAULT(DDEF),
        .LOCK_CYCLES(LC), .LOCK_CNT_WIDTH(LCW)
    ) dut (
        .clock_in(clock_in),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .div_i(div_i),
        .div_load(div_load),
        .locked(locked),
        .rst_out_n(rst_out_n),
`ifdef CLOCK_ENABLE_GEN_LOSS_COUNT_EN
        .lock_loss_count(lock_loss_count),
`endif
        .clk_en(clk_en)
    );

    always #5 clock_in = ~clock_in;

    int n_vec = 0;
    int n_err = 0;

    // Model: pll history, run length of consecutive synchronised highs, phase since last realignment.
    bit            m_s1, m_s2;
    int            m_run;
    bit            m_lk, m_rst;
    bit [CH-1:0]   m_en;
    int            m_ph [CH];
    int            m_d  [CH];
    int            m_loss;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0;
        m_lk = 1'b0; m_rst = 1'b0; m_en = '0; m_loss = 0;
        for (int c = 0; c < CH; c++) begin
            m_ph[c] = 0;
            m_d[c]  = DDEF;
        end
    endtask

    task automatic model_edge();
        bit smp, lk_old, lk_new, running;
        smp    = m_s2;
        lk_old = m_lk;
        m_run  = smp ? ((m_run > LC + 1) ? m_run : m_run + 1) : 0;
        lk_new = (m_run >= LC + 1);
        m_s2   = m_s1;
        m_s1   = pll_locked;
        running = lk_old && lk_new;
        for (int c = 0; c < CH; c++) begin
            if (div_load) begin
                m_d[c]  = int'(div_i[c*DW +: DW]);
                m_ph[c] = 0;
                m_en[c] = 1'b0;
            end else if (!running) begin
                m_ph[c] = 0;
                m_en[c] = 1'b0;
            end else begin
                m_ph[c] = m_ph[c] + 1;
                m_en[c] = (m_d[c] != 0) && ((m_ph[c] % m_d[c]) == 0);
            end
        end
        if (lk_old && !lk_new && m_loss < 255) m_loss = m_loss + 1;
        m_rst = lk_new && lk_old;
        m_lk  = lk_new;
    endtask

    task automatic tick(input bit p, input bit ld, input logic [CH*DW-1:0] d);
        pll_locked = p;
        div_load   = ld;
        div_i      = d;
        @(posedge clock_in);
        model_edge();
        @(negedge clock_in);
        check_eq("locked", 32'(locked), 32'(m_lk));
        check_eq("rst_out_n", 32'(rst_out_n), 32'(m_rst));
        check_eq("clk_en", 32'(clk_en), 32'(m_en));
`ifdef CLOCK_ENABLE_GEN_LOSS_COUNT_EN
        check_eq("lock_loss_count", 32'(lock_loss_count), 32'(m_loss));
`endif
    endtask

    initial begin
        logic [CH*DW-1:0] dv;
        int  lat;
        int  drop_left;
        int  ld_left;
        bit  p, ld;

        dv         = {8'd2, 8'd2};
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        div_load   = 1'b0;
        div_i      = dv;
        model_reset();
        repeat (3) @(negedge clock_in);
        check_eq("reset_locked", 32'(locked), 32'd0);
        check_eq("reset_rst_out_n", 32'(rst_out_n), 32'd0);
        check_eq("reset_clk_en", 32'(clk_en), 32'd0);
        reset_n = 1'b1;

        // Lock latency from reset release: 2 sync + 16 count + 1 register.
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            tick(1'b1, 1'b0, dv);
            if (locked === 1'b1) lat = n;
        end
        check_eq("lock_latency", 32'(lat), 32'd19);
        repeat (8) tick(1'b1, 1'b0, dv);

        // Lock loss: locked and rst_out_n fall 3 cycles after the input.
        lat = -1;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            tick(1'b0, 1'b0, dv);
            if (locked === 1'b0) lat = n;
        end
        check_eq("unlock_latency", 32'(lat), 32'd3);
        repeat (4) tick(1'b0, 1'b0, dv);

        // Glitch around count 10 restarts the filter.
        repeat (13) tick(1'b1, 1'b0, dv);
        tick(1'b0, 1'b0, dv);
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            tick(1'b1, 1'b0, dv);
            if (locked === 1'b1) lat = n;
        end
        check_eq("glitch_relock_latency", 32'(lat), 32'd19);
        repeat (6) tick(1'b1, 1'b0, dv);

        dv = {8'd3, 8'd5};
        tick(1'b1, 1'b1, dv);
        repeat (12) tick(1'b1, 1'b0, dv);
        dv = {8'd0, 8'd1};
        tick(1'b1, 1'b1, dv);
        repeat (8) tick(1'b1, 1'b0, dv);
        dv = {8'd3, 8'd2};
        tick(1'b1, 1'b1, dv);
        repeat (6) tick(1'b1, 1'b0, dv);
        repeat (6) tick(1'b0, 1'b0, dv);
        repeat (30) tick(1'b1, 1'b0, dv);

        drop_left = 0;
        ld_left   = 0;
        for (int n = 0; n < 3000; n++) begin
            if (drop_left == 0 && $urandom_range(0, 249) == 0) drop_left = $urandom_range(1, 30);
            p = (drop_left == 0);
            if (drop_left > 0) drop_left--;
            if (ld_left == 0 && $urandom_range(0, 24) == 0) begin
                ld_left = $urandom_range(1, 3);
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(0, 9) == 0) dv[c*DW +: DW] = 8'($urandom_range(0, 255));
                    else dv[c*DW +: DW] = 8'($urandom_range(0, 9));
                end
            end
            ld = (ld_left > 0);
            if (ld_left > 0) ld_left--;
            tick(p, ld, dv);
        end

        // Reset asserted mid-operation with both channels running continuously.
        dv = {8'd1, 8'd1};
        tick(1'b1, 1'b1, dv);
        repeat (30) tick(1'b1, 1'b0, dv);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_reset_locked", 32'(locked), 32'd0);
        check_eq("async_reset_rst_out_n", 32'(rst_out_n), 32'd0);
        check_eq("async_reset_clk_en", 32'(clk_en), 32'd0);
`ifdef CLOCK_ENABLE_GEN_LOSS_COUNT_EN
        check_eq("async_reset_loss", 32'(lock_loss_count), 32'd0);
`endif
        model_reset();
        @(negedge clock_in);
        reset_n = 1'b1;
        repeat (30) tick(1'b1, 1'b0, dv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
